// File: rtl/nv_nvdla_csb_pkg.sv
// Shared CSB slave definitions: request/response field positions and the
// decoded request struct carried through slave request FIFOs.
package nv_nvdla_csb_pkg;

  localparam int REQ_W       = 63;
  localparam int ADDR_LSB    = 0;
  localparam int ADDR_MSB    = 21;
  localparam int WDAT_LSB    = 22;
  localparam int WDAT_MSB    = 53;
  localparam int WRITE_BIT   = 54;
  localparam int NPOSTED_BIT = 55;

  localparam int RESP_W    = 34;
  localparam int RESP_ERR  = 32;
  localparam int RESP_WACK = 33;

  typedef struct packed {
    logic [21:0] addr;
    logic        write;
    logic        nposted;
  } csb_req_t;

  function automatic csb_req_t decode_req(input logic [REQ_W-1:0] pd);
    csb_req_t r;
    r.addr    = pd[ADDR_MSB:ADDR_LSB];
    r.write   = pd[WRITE_BIT];
    r.nposted = pd[NPOSTED_BIT];
    return r;
  endfunction

endpackage

// File: rtl/nv_nvdla_csb_req_fifo.sv
// Parametrised synchronous request FIFO shared by CSB slaves.
// Pointers carry one extra wrap bit; full = wrap bits differ, index bits equal.
module nv_nvdla_csb_req_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/nv_nvdla_cfgrom_param.sv
// Parametrised CSB configuration ROM with request FIFO, RD_LAT response pipe,
// and optional error counter (NVDLA_CFGROM_ERRCNT_EN).
module nv_nvdla_cfgrom_param
  import nv_nvdla_csb_pkg::*;
#(
  parameter int                  ENTRIES   = 64,
  parameter logic [21:0]         BASE_ADDR = 22'h0,
  parameter int                  RD_LAT    = 1,
  parameter int                  REQ_DEPTH = 2,
  parameter logic [ENTRIES*32-1:0] ROM_DATA = '0
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic [REQ_W-1:0]  csb2cfgrom_req_pd,
  input  logic              csb2cfgrom_req_pvld,
  output logic              csb2cfgrom_req_prdy,
  output logic [RESP_W-1:0] cfgrom2csb_resp_pd,
  output logic              cfgrom2csb_resp_valid
);

  localparam int          OFF_W    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [22:0] END_ADDR = {1'b0, BASE_ADDR} + 23'(ENTRIES);

  // Request side: transfer on pvld && prdy; no response backpressure exists,
  // so the FIFO drains one entry per cycle whenever it holds anything.
  csb_req_t push_req;
  csb_req_t head;
  logic     fifo_full;
  logic     fifo_empty;
  logic     push;
  logic     pop;
  logic     unused_fields;

  assign push_req            = decode_req(csb2cfgrom_req_pd);
  assign csb2cfgrom_req_prdy = !fifo_full && !nvdla_core_rst;
  assign push                = csb2cfgrom_req_pvld && csb2cfgrom_req_prdy;
  assign pop                 = !fifo_empty;
  assign unused_fields       = ^{csb2cfgrom_req_pd[62:56], csb2cfgrom_req_pd[WDAT_MSB:WDAT_LSB]};

  nv_nvdla_csb_req_fifo #(
    .WIDTH ($bits(csb_req_t)),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk     (nvdla_core_clk),
    .rst     (nvdla_core_rst),
    .push    (push),
    .wr_data (push_req),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  logic [22:0]      addr_x;
  logic [21:0]      off_full;
  logic [OFF_W-1:0] off;
  logic             hit;
  logic             cnt_hit;
  logic [31:0]      rom_word;
  logic [15:0]      errcnt_val;

  assign addr_x   = {1'b0, head.addr};
  assign hit      = (addr_x >= {1'b0, BASE_ADDR}) && (addr_x < END_ADDR);
  assign off_full = head.addr - BASE_ADDR;
  assign off      = off_full[OFF_W-1:0];
  assign rom_word = hit ? ROM_DATA[{off, 5'b0} +: 32] : 32'h0;

`ifdef NVDLA_CFGROM_ERRCNT_EN
  logic [15:0] errcnt;
  assign cnt_hit    = (addr_x == END_ADDR) && !head.write;
  assign errcnt_val = errcnt;
`else
  assign cnt_hit    = 1'b0;
  assign errcnt_val = 16'h0;
`endif

  logic              stage_v;
  logic [RESP_W-1:0] stage_d;
  logic              err_event;

  always_comb begin
    stage_v   = 1'b0;
    stage_d   = '0;
    err_event = 1'b0;
    if (pop) begin
      if (head.write) begin
        // Posted writes become bubbles; non-posted ones get an error ack.
        stage_v   = head.nposted;
        stage_d   = {1'b1, 1'b1, 32'h0};
        err_event = 1'b1;
      end else if (hit) begin
        stage_v = 1'b1;
        stage_d = {1'b0, 1'b0, rom_word};
      end else if (cnt_hit) begin
        stage_v = 1'b1;
        stage_d = {1'b0, 1'b0, 16'h0, errcnt_val};
      end else begin
        stage_v   = 1'b1;
        stage_d   = {1'b0, 1'b1, 32'h0};
        err_event = 1'b1;
      end
    end
  end

`ifdef NVDLA_CFGROM_ERRCNT_EN
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      errcnt <= 16'h0;
    end else if (pop && cnt_hit) begin
      errcnt <= {15'h0, err_event};
    end else if (err_event && errcnt != 16'hFFFF) begin
      errcnt <= errcnt + 16'h1;
    end
  end
`else
  logic unused_err;
  assign unused_err = ^{err_event, errcnt_val, cnt_hit};
`endif

  // Data stages only load on valid so the output holds its last response.
  logic              v_pipe [RD_LAT];
  logic [RESP_W-1:0] d_pipe [RD_LAT];

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        v_pipe[i] <= 1'b0;
        d_pipe[i] <= '0;
      end
    end else begin
      v_pipe[0] <= stage_v;
      if (stage_v) d_pipe[0] <= stage_d;
      for (int i = 1; i < RD_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        if (v_pipe[i-1]) d_pipe[i] <= d_pipe[i-1];
      end
    end
  end

  assign cfgrom2csb_resp_valid = v_pipe[RD_LAT-1] && !nvdla_core_rst;
  assign cfgrom2csb_resp_pd    = d_pipe[RD_LAT-1];

endmodule

// File: tb/tb_nv_nvdla_cfgrom_param.sv
// Self-checking bench for nv_nvdla_cfgrom_param: randomized CSB traffic
// scored against a spec-level model of the ROM, decode and error counter.
module tb_nv_nvdla_cfgrom_param;

  localparam int          ENTRIES = 64;
  localparam logic [21:0] BASE    = 22'h100;
  localparam int          RD_LAT  = 1;
  localparam int          DEPTH   = 2;

  function automatic logic [31:0] rom_val(input int i);
    if (i == 5) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ 32'h0BAD0000;
  endfunction

  function automatic logic [ENTRIES*32-1:0] build_rom();
    logic [ENTRIES*32-1:0] r;
    r = '0;
    for (int i = 0; i < ENTRIES; i++) r[32*i +: 32] = rom_val(i);
    return r;
  endfunction

  localparam logic [ENTRIES*32-1:0] ROM = build_rom();

  // clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [62:0] req_pd = '0;
  logic        req_pvld = 1'b0;
  logic        req_prdy;
  logic [33:0] resp_pd;
  logic        resp_valid;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nv_nvdla_cfgrom_param #(
    .ENTRIES   (ENTRIES),
    .BASE_ADDR (BASE),
    .RD_LAT    (RD_LAT),
    .REQ_DEPTH (DEPTH),
    .ROM_DATA  (ROM)
  ) dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rst        (rst),
    .csb2cfgrom_req_pd     (req_pd),
    .csb2cfgrom_req_pvld   (req_pvld),
    .csb2cfgrom_req_prdy   (req_prdy),
    .cfgrom2csb_resp_pd    (resp_pd),
    .cfgrom2csb_resp_valid (resp_valid)
  );

  // scoreboard
  logic [33:0] exp_q[$];
  int          resp_cyc_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_resp = 0;
  int          last_resp_cyc = 0;
  logic [33:0] last_pd = '0;
  int          acc_cyc = 0;
  int          n_stall = 0;
  int          model_errcnt = 0;

  function automatic void model_push(input logic [21:0] addr, input logic wr, input logic np);
    int a;
    a = int'(addr);
    if (wr) begin
      if (model_errcnt < 65535) model_errcnt++;
      if (np) exp_q.push_back({1'b1, 1'b1, 32'h0});
    end else if (a >= int'(BASE) && a < int'(BASE) + ENTRIES) begin
      exp_q.push_back({2'b00, rom_val(a - int'(BASE))});
    end else begin
`ifdef NVDLA_CFGROM_ERRCNT_EN
      if (a == int'(BASE) + ENTRIES) begin
        exp_q.push_back({2'b00, 16'h0, 16'(model_errcnt)});
        model_errcnt = 0;
        return;
      end
`endif
      if (model_errcnt < 65535) model_errcnt++;
      exp_q.push_back({1'b0, 1'b1, 32'h0});
    end
  endfunction

  always @(negedge clk) begin
    if (resp_valid) begin
      n_resp++;
      last_resp_cyc = cyc;
      last_pd = resp_pd;
      resp_cyc_q.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_resp: got pd=%h, required no response", resp_pd);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        if (resp_pd !== e) begin
          n_fail++;
          $display("FAIL resp_data: got pd=%h, required %h", resp_pd, e);
        end
      end
    end
  end

  // driver tasks (called at posedge+1, return at posedge+1 with pvld still high)
  task automatic drive_req(input logic [21:0] addr, input logic wr, input logic np);
    int waited;
    req_pd   = {2'($urandom), 4'($urandom), 1'($urandom), np, wr, $urandom, addr};
    req_pvld = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!req_prdy) begin
      waited++;
      n_stall++;
      if (waited > 20) begin
        n_checks++;
        n_fail++;
        $display("FAIL prdy_timeout: prdy=%b, required 1 within 20 cycles", req_prdy);
        req_pvld = 1'b0;
        return;
      end
      @(posedge clk); #1;
      @(negedge clk);
    end
    acc_cyc = cyc;
    model_push(addr, wr, np);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_pvld = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int t;
    req_pvld = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    idle(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_pvld = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (req_prdy !== 1'b0 || resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: prdy=%b valid=%b, required 0 0", req_prdy, resp_valid);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_errcnt = 0;
    @(negedge clk);
    n_checks++;
    if (req_prdy !== 1'b1 || resp_valid !== 1'b0 || resp_pd !== 34'h0) begin
      n_fail++;
      $display("FAIL post_reset: prdy=%b valid=%b pd=%h, required 1 0 0", req_prdy, resp_valid, resp_pd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int t0;
    drive_req(22'h105, 1'b0, 1'b0);
    t0 = acc_cyc;
    drain();
    n_checks++;
    if (last_resp_cyc - t0 != 1 + RD_LAT || last_pd !== {2'b00, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL read_latency: lat=%0d pd=%h, required %0d %h", last_resp_cyc - t0, last_pd, 1 + RD_LAT, {2'b00, 32'hDEADBEEF});
    end
  endtask

  task automatic test_miss();
    drive_req(22'h0FF, 1'b0, 1'b0);
    drive_req(22'h140, 1'b0, 1'b0);
    drain();
    n_checks++;
    if (last_pd !== {1'b0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL read_miss: pd=%h, required %h", last_pd, {1'b0, 1'b1, 32'h0});
    end
  endtask

  task automatic test_write();
    int cnt;
    drive_req(22'h105, 1'b1, 1'b1);
    drain();
    n_checks++;
    if (last_pd !== {1'b1, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL nposted_wack: pd=%h, required %h", last_pd, {1'b1, 1'b1, 32'h0});
    end
    drive_req(22'h105, 1'b0, 1'b0);
    drain();
    n_checks++;
    if (last_pd !== {2'b00, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL rom_after_write: pd=%h, required %h", last_pd, {2'b00, 32'hDEADBEEF});
    end
    cnt = n_resp;
    drive_req(22'h105, 1'b1, 1'b0);
    idle(6);
    n_checks++;
    if (n_resp != cnt) begin
      n_fail++;
      $display("FAIL posted_write: responses=%0d, required %0d", n_resp, cnt);
    end
  endtask

  task automatic test_back_to_back();
    resp_cyc_q.delete();
    n_stall = 0;
    for (int i = 0; i < ENTRIES; i++) drive_req(BASE + 22'(i), 1'b0, 1'b0);
    drain();
    n_checks++;
    if (n_stall != 0) begin
      n_fail++;
      $display("FAIL b2b_prdy: stalls=%0d, required 0", n_stall);
    end
    n_checks++;
    if (resp_cyc_q.size() != ENTRIES ||
        resp_cyc_q[resp_cyc_q.size()-1] - resp_cyc_q[0] != ENTRIES - 1) begin
      n_fail++;
      $display("FAIL b2b_gapless: count=%0d, required %0d contiguous", resp_cyc_q.size(), ENTRIES);
    end
  endtask

  task automatic test_random();
    logic [21:0] a;
    logic        wr;
    logic        np;
    for (int i = 0; i < 200; i++) begin
      a  = 22'($urandom_range(int'(BASE) - 8, int'(BASE) + ENTRIES + 8));
      wr = ($urandom_range(0, 3) == 0);
      np = 1'($urandom);
      drive_req(a, wr, np);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    int cnt;
    int t0;
    drive_req(22'h110, 1'b0, 1'b0);
    drive_req(22'h0FF, 1'b0, 1'b0);
    drive_req(22'h111, 1'b0, 1'b0);
    rst = 1'b1;
    req_pvld = 1'b0;
    exp_q.delete();
    model_errcnt = 0;
    cnt = n_resp;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (req_prdy !== 1'b0 || resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midflight_reset: prdy=%b valid=%b, required 0 0", req_prdy, resp_valid);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(8);
    n_checks++;
    if (n_resp != cnt) begin
      n_fail++;
      $display("FAIL flushed: responses=%0d, required %0d", n_resp, cnt);
    end
    drive_req(22'h13F, 1'b0, 1'b0);
    t0 = acc_cyc;
    drain();
    n_checks++;
    if (last_resp_cyc - t0 != 1 + RD_LAT || last_pd !== {2'b00, rom_val(63)}) begin
      n_fail++;
      $display("FAIL post_reset_read: lat=%0d pd=%h, required %0d %h", last_resp_cyc - t0, last_pd, 1 + RD_LAT, {2'b00, rom_val(63)});
    end
  endtask

`ifdef NVDLA_CFGROM_ERRCNT_EN
  task automatic test_errcnt();
    drive_req(22'h140, 1'b0, 1'b0);
    drain();
    drive_req(22'h0FF, 1'b0, 1'b0);
    drive_req(22'h141, 1'b0, 1'b0);
    drive_req(22'h0F0, 1'b0, 1'b0);
    drive_req(22'h140, 1'b0, 1'b0);
    drain();
    n_checks++;
    if (last_pd !== 34'h3) begin
      n_fail++;
      $display("FAIL errcnt_read: pd=%h, required %h", last_pd, 34'h3);
    end
    drive_req(22'h140, 1'b0, 1'b0);
    drain();
    n_checks++;
    if (last_pd !== 34'h0) begin
      n_fail++;
      $display("FAIL errcnt_clear: pd=%h, required %h", last_pd, 34'h0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_miss();
    test_write();
    test_back_to_back();
    test_random();
    test_reset_midflight();
`ifdef NVDLA_CFGROM_ERRCNT_EN
    test_errcnt();
`endif
    idle(4);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: %0d outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_cfgrom_param.md
# nv_nvdla_cfgrom_param

Parametrised CSB-attached configuration ROM. It answers the fixed hardware-capability descriptor reads that software issues at boot, and it supports configurable table depth, base address, read latency and request buffering. Unlike the fixed-function cfgrom, it buffers requests, flags out-of-range and write accesses, and generates write acknowledges. It sits on the CSB fan-out next to the other per-unit CSB slaves, inside the nvdla_core_clk domain.

## Interface
Parameters:
- ENTRIES, 64: number of 32-bit ROM words (1..1024).
- BASE_ADDR, 22'h0: CSB word address of entry 0.
- RD_LAT, 1: pipeline stages from FIFO pop to response (1..4).
- REQ_DEPTH, 2: request FIFO depth (power of two, 2..8).
- ROM_DATA, all-zero: ENTRIES*32-bit packed contents; entry i is at [32*i+31:32*i].

Ports:
- nvdla_core_clk, in, 1: the single clock.
- nvdla_core_rst, in, 1: synchronous, active-high reset.
- csb2cfgrom_req_pd, in, 63: request fields are addr[21:0], wdat[53:22], write[54], nposted[55], srcpriv[56], wrbe[60:57], level[62:61].
- csb2cfgrom_req_pvld, in, 1: request valid.
- csb2cfgrom_req_prdy, out, 1: request ready.
- cfgrom2csb_resp_pd, out, 34: rdat[31:0], error[32], is_write_ack[33].
- cfgrom2csb_resp_valid, out, 1: single-cycle response strobe. There is no backpressure.

## Operation
- A request is accepted when pvld && prdy. prdy = !fifo_full.
- The FIFO pops one entry every cycle it is non-empty. The downstream path never stalls.
- Decode: hit = (addr >= BASE_ADDR) && (addr < BASE_ADDR+ENTRIES); offset = addr - BASE_ADDR, truncated to clog2(ENTRIES) bits.
- Read hit: rdat = ROM_DATA[offset], error = 0, is_write_ack = 0.
- Read miss: rdat = 0, error = 1, is_write_ack = 0.
- Non-posted write (write=1, nposted=1): the ROM is unchanged. Response is rdat = 0, error = 1, is_write_ack = 1, regardless of hit.
- Posted write (write=1, nposted=0): dropped. No response is issued. It occupies its pipeline slot as a bubble.
- Responses leave in acceptance order.
- srcpriv, wrbe and level are ignored.
- Reset mid-operation clears the FIFO and pipeline. In-flight requests are discarded without responses.

## Timing
- Reset values: prdy = 0 during reset and 1 in the first cycle after reset. resp_valid = 0. resp_pd = 0. FIFO is empty.
- Latency: a request accepted at cycle T with the FIFO empty produces resp_valid at T+1+RD_LAT.
- Throughput: one request per cycle sustained. prdy stays 1 because pop and push rate match.
- Simultaneous push and pop on a full FIFO are not allowed, because prdy is low. On a non-full FIFO both happen in the same cycle and the occupancy is unchanged.
- FIFO pointers are clog2(REQ_DEPTH)+1 bits wide and wrap naturally. Full = MSBs differ and the low bits are equal.
- resp_pd holds its last value when resp_valid = 0.

## Configuration
- NVDLA_CFGROM_ERRCNT_EN, when defined:
  - Adds a 16-bit saturating counter. It increments by 1 for each read miss, each non-posted write and each posted write, at FIFO pop. It saturates at 16'hFFFF.
  - A read of address BASE_ADDR+ENTRIES returns {16'h0, errcnt} with error = 0, and the counter then clears. If an error event pops in the same cycle, the counter reads 0 and then loads 1.
  - The counter resets to 0.
- When not defined: the counter is absent, and BASE_ADDR+ENTRIES decodes as an ordinary miss.

## Structure
- Shared package nv_nvdla_csb_pkg holds:
  - the request/response field-position localparams (ADDR_LSB/MSB, WDAT, WRITE, NPOSTED, RESP_ERR, RESP_WACK);
  - a typedef for the decoded request struct {addr, write, nposted}.
- One sub-module: nv_nvdla_csb_req_fifo. It is a parametrised synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty, reused by other CSB slaves.
- The ROM lookup, the RD_LAT-deep valid/data shift pipeline and the error counter live in the top module.

## Test plan
- ENTRIES=64, BASE_ADDR=22'h100, ROM_DATA[5]=32'hDEADBEEF: read addr 22'h105 accepted at T -> resp_valid at T+2 (RD_LAT=1), pd = {1'b0, 1'b0, 32'hDEADBEEF}.
- Read addr 22'h0FF, then 22'h140 -> two responses, each with error=1 and rdat=0.
- Non-posted write to 22'h105 -> pd = {1'b1, 1'b1, 32'h0}. A following read of 22'h105 still returns 32'hDEADBEEF. A posted write produces no resp_valid.
- Back-to-back reads of 22'h100..22'h13F for 64 cycles with pvld held high -> prdy stays 1, 64 in-order responses, no gaps.
- Assert reset with 3 requests in flight -> no responses follow. resp_valid=0 and prdy=0 during reset. The first post-reset read responds at nominal latency.
- With NVDLA_CFGROM_ERRCNT_EN: 3 misses then a read of 22'h140 -> rdat = 32'h3. A second read of 22'h140 -> rdat = 32'h0.
